// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA engine: passes CPU traffic to the bus in idle, and on a $4014 write halts the CPU and copies one page to OAMDATA.
// Optional feature macro: OAM_DMA_ODD_ALIGN_EN (adds the odd-cycle ALIGN state, giving 513/514-cycle transfers).
module nes_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        CPU_CLK,
    input  logic        RESET_n,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DATA_OUT,
    input  logic        CPU_RW_n,
    output logic        CPU_ENABLE,
    input  logic [7:0]  BUS_DATA_IN,
    output logic [15:0] ADDR_BUS,
    output logic [7:0]  BUS_DATA_OUT,
    output logic        BUS_RW_n,
    output logic        DMA_ACTIVE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
`ifdef OAM_DMA_ODD_ALIGN_EN
        S_ALIGN,
`endif
        S_READ,
        S_WRITE
    } state_t;

    state_t     r_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_latch;
`ifdef OAM_DMA_ODD_ALIGN_EN
    logic       r_parity;
`endif

    logic w_trigger;
    assign w_trigger = (CPU_ADDR == DMA_REG_ADDR) && !CPU_RW_n;

    // Transfer sequencer; a trigger is only honoured from idle.
    always_ff @(posedge CPU_CLK) begin
        if (!RESET_n) begin
            r_state  <= S_IDLE;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_latch  <= 8'h00;
`ifdef OAM_DMA_ODD_ALIGN_EN
            r_parity <= 1'b0;
`endif
        end else begin
`ifdef OAM_DMA_ODD_ALIGN_EN
            r_parity <= ~r_parity;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_state <= S_HALT;
                        r_page  <= CPU_DATA_OUT;
                        r_idx   <= 8'h00;
                    end
                end
                S_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                    r_state <= r_parity ? S_ALIGN : S_READ;
`else
                    r_state <= S_READ;
`endif
                end
`ifdef OAM_DMA_ODD_ALIGN_EN
                S_ALIGN: r_state <= S_READ;
`endif
                S_READ: begin
                    r_latch <= BUS_DATA_IN;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_idx == 8'hFF) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= S_READ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus mux: passthrough by default, DMA overrides while it owns the bus.
    always_comb begin
        ADDR_BUS     = CPU_ADDR;
        BUS_DATA_OUT = CPU_DATA_OUT;
        BUS_RW_n     = CPU_RW_n;
        CPU_ENABLE   = 1'b1;
        case (r_state)
            S_IDLE: ;
            S_READ: begin
                ADDR_BUS   = {r_page, r_idx};
                BUS_RW_n   = 1'b1;
                CPU_ENABLE = 1'b0;
            end
            S_WRITE: begin
                ADDR_BUS     = OAM_DATA_ADDR;
                BUS_DATA_OUT = r_latch;
                BUS_RW_n     = 1'b0;
                CPU_ENABLE   = 1'b0;
            end
            default: begin
                BUS_RW_n   = 1'b1;
                CPU_ENABLE = 1'b0;
            end
        endcase
    end

    assign DMA_ACTIVE = (r_state != S_IDLE);

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: passthrough, even/odd DMA timing and data, reset abort, non-triggers.
module tb_nes_oam_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw_n;
    logic        cpu_en;
    logic [7:0]  bus_din;
    logic [15:0] addr_bus;
    logic [7:0]  bus_dout;
    logic        bus_rw_n;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic        m_par;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    nes_oam_dma dut (
        .CPU_CLK      (clk),
        .RESET_n      (rst_n),
        .CPU_ADDR     (cpu_addr),
        .CPU_DATA_OUT (cpu_dout),
        .CPU_RW_n     (cpu_rw_n),
        .CPU_ENABLE   (cpu_en),
        .BUS_DATA_IN  (bus_din),
        .ADDR_BUS     (addr_bus),
        .BUS_DATA_OUT (bus_dout),
        .BUS_RW_n     (bus_rw_n),
        .DMA_ACTIVE   (dma_active)
    );

    // Zero-latency memory map.
    assign bus_din = mem[addr_bus];

    // Reference cycle parity: cleared on a reset edge, toggles on every other edge.
    always @(posedge clk) begin
        if (!rst_n) m_par <= 1'b0;
        else        m_par <= ~m_par;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge clk);
        cpu_addr = a;
        cpu_dout = d;
        cpu_rw_n = rw;
        #1;
    endtask

    // Trigger a DMA of page $03 with the requested parity in HALT and measure it.
    task automatic run_dma(input string tag, input logic want_par, input int exp_halt, input int exp_ovh);
        int halt = 0, ovh = 0, nwr = 0, nrd = 0, err = 0;
        logic [7:0] last = 8'h00;
        @(negedge clk);
        if (m_par == want_par) begin
            cpu_addr = 16'hC000; cpu_rw_n = 1'b1;
            @(negedge clk);
        end
        cpu_addr = 16'h4014; cpu_dout = 8'h03; cpu_rw_n = 1'b0;
        #1;
        chk({tag, "_trig_addr"}, 32'(addr_bus), 32'h4014);
        chk({tag, "_trig_rw"},   32'(bus_rw_n), 32'h0);
        chk({tag, "_trig_en"},   32'(cpu_en),   32'h1);
        for (int c = 0; c < 600; c++) begin
            drive(16'hC000, 8'h00, 1'b1);
            if (cpu_en) break;
            halt++;
            if (!bus_rw_n) begin
                if (addr_bus != 16'h2004 || bus_dout != (8'(nwr) ^ 8'hA5)) err++;
                last = bus_dout;
                nwr++;
            end else if (addr_bus == 16'hC000) begin
                ovh++;
            end else begin
                if (addr_bus != {8'h03, 8'(nrd)}) err++;
                nrd++;
            end
        end
        chk({tag, "_halt"},   32'(halt), 32'(exp_halt));
        chk({tag, "_ovh"},    32'(ovh),  32'(exp_ovh));
        chk({tag, "_writes"}, 32'(nwr),  32'd256);
        chk({tag, "_errs"},   32'(err),  32'd0);
        chk({tag, "_last"},   32'(last), 32'h5A);
        chk({tag, "_active"}, 32'(dma_active), 32'h0);
    endtask

    initial begin
        int found, bad;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
        rst_n = 1'b0; cpu_addr = 16'h1234; cpu_dout = 8'h77; cpu_rw_n = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_en",     32'(cpu_en),     32'h1);
        chk("rst_active", 32'(dma_active), 32'h0);
        chk("rst_addr",   32'(addr_bus),   32'h1234);
        chk("rst_dout",   32'(bus_dout),   32'h77);
        rst_n = 1'b1;

        // Idle passthrough
        drive(16'h8000, 8'h00, 1'b1);
        chk("pt_rd_addr", 32'(addr_bus), 32'h8000);
        chk("pt_rd_rw",   32'(bus_rw_n), 32'h1);
        chk("pt_rd_en",   32'(cpu_en),   32'h1);
        drive(16'h0200, 8'h5A, 1'b0);
        chk("pt_wr_addr", 32'(addr_bus), 32'h0200);
        chk("pt_wr_rw",   32'(bus_rw_n), 32'h0);
        chk("pt_wr_data", 32'(bus_dout), 32'h5A);
        chk("pt_wr_en",   32'(cpu_en),   32'h1);

        // Even and odd alignment
        run_dma("even", 1'b0, 513, 1);
`ifdef OAM_DMA_ODD_ALIGN_EN
        run_dma("odd", 1'b1, 514, 2);
`else
        run_dma("odd", 1'b1, 513, 1);
`endif

        // Reset during the WRITE of index $40
        drive(16'h4014, 8'h03, 1'b0);
        found = 0;
        for (int c = 0; c < 600; c++) begin
            drive(16'hC000, 8'h00, 1'b1);
            if (!bus_rw_n && addr_bus == 16'h2004 && bus_dout == (8'h40 ^ 8'hA5)) begin
                found = 1;
                break;
            end
        end
        chk("abort_found", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("abort_en",     32'(cpu_en),     32'h1);
        chk("abort_active", 32'(dma_active), 32'h0);
        chk("abort_addr",   32'(addr_bus),   32'hC000);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            drive(16'hC000, 8'h00, 1'b1);
            if (!cpu_en || dma_active || (!bus_rw_n && addr_bus == 16'h2004)) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'd0);

        // Non-triggers
        drive(16'h4014, 8'h07, 1'b1);
        drive(16'h4015, 8'h07, 1'b0);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            drive(16'hC000, 8'h00, 1'b1);
            if (!cpu_en || dma_active) bad++;
        end
        chk("nontrig", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nes_oam_dma.md
# nes_oam_dma

Sprite OAM DMA engine sitting between the CPU_2A03 core and the shared system bus in the NES top level. In idle it passes the CPU's address, write data and RW_n straight onto the bus. A CPU write to $4014 halts the CPU through CPU_ENABLE and then copies 256 bytes from page $XX00–$XXFF to the PPU OAMDATA port ($2004). When the copy is done, bus ownership returns to the CPU.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - CPU_CLK  in  1  CPU-rate clock; all state updates on its rising edge.
  - RESET_n  in  1  synchronous active-low reset.
- CPU side:
  - CPU_ADDR  in  16  CPU address.
  - CPU_DATA_OUT  in  8  CPU write data.
  - CPU_RW_n  in  1  CPU read/write (0 = write).
  - CPU_ENABLE  out  1  CPU clock enable; 0 halts the CPU.
- Bus side:
  - BUS_DATA_IN  in  8  read data returned by the bus/memory map.
  - ADDR_BUS  out  16  bus address.
  - BUS_DATA_OUT  out  8  bus write data.
  - BUS_RW_n  out  1  bus read/write.
- Status:
  - DMA_ACTIVE  out  1  high whenever state ≠ IDLE.

## Operation
- Registers:
  - STATE
  - PAGE[7:0]
  - IDX[7:0]
  - LATCH[7:0]
  - PARITY (toggles every cycle; cleared by reset)
- States and transitions:
  - IDLE → HALT when CPU_ADDR == DMA_REG_ADDR and CPU_RW_n == 0; at the same edge PAGE ← CPU_DATA_OUT and IDX ← 0.
  - HALT → ALIGN if PARITY == 1 in HALT (odd-alignment rule, see Configuration); otherwise HALT → READ.
  - ALIGN → READ.
  - READ → WRITE; LATCH ← BUS_DATA_IN at the end of the READ cycle.
  - WRITE → READ with IDX ← IDX+1 if IDX ≠ 8'hFF; WRITE → IDLE if IDX == 8'hFF.
  - IDX is 8-bit with no carry into PAGE. The source never crosses a page.
- Outputs by state (combinational from STATE and registers):
  - IDLE:
    - ADDR_BUS = CPU_ADDR
    - BUS_DATA_OUT = CPU_DATA_OUT
    - BUS_RW_n = CPU_RW_n
    - CPU_ENABLE = 1
  - HALT / ALIGN:
    - ADDR_BUS = CPU_ADDR
    - BUS_RW_n = 1 (forced read, no side-effecting write)
    - BUS_DATA_OUT = CPU_DATA_OUT
    - CPU_ENABLE = 0
  - READ:
    - ADDR_BUS = {PAGE, IDX}
    - BUS_RW_n = 1
    - CPU_ENABLE = 0
  - WRITE:
    - ADDR_BUS = OAM_DATA_ADDR
    - BUS_DATA_OUT = LATCH
    - BUS_RW_n = 0
    - CPU_ENABLE = 0
- Boundary conditions:
  - Writes to $4014 while not IDLE are ignored. The CPU is halted, so they cannot occur in normal use.
  - A CPU read of $4014 never triggers DMA.
  - RESET_n low in any state: at that edge STATE ← IDLE, PAGE, IDX and LATCH ← 0, PARITY ← 0. An in-flight transfer is abandoned, with no further bus writes.

## Timing
- Reset values, from the first rising edge with RESET_n low:
  - CPU_ENABLE = 1
  - DMA_ACTIVE = 0
  - bus outputs are pure passthrough of the CPU inputs.
- Trigger write in cycle N: the write itself reaches the bus in cycle N (passthrough). HALT is in cycle N+1.
- First READ:
  - cycle N+2 on even alignment
  - cycle N+3 when ALIGN is inserted.
- Transfer length:
  - 256 READ/WRITE pairs.
  - Total halt = 513 cycles (even) or 514 cycles (odd).
- After the final WRITE (IDX = FF), CPU_ENABLE = 1 in the next cycle.
- Read data is sampled only at the end of READ cycles. Bus read latency must be 0 cycles, i.e. combinational memory-map read.

## Configuration
- OAM_DMA_ODD_ALIGN_EN
  - Defined: the HALT→ALIGN branch on PARITY == 1 is present, matching 2A03 513/514-cycle behaviour.
  - Undefined: PARITY and ALIGN are compiled out. HALT always goes to READ, and every DMA takes exactly 513 cycles.

## Test plan
- Passthrough in IDLE: CPU read $8000, then write $0200 = 8'h5A. Required:
  - ADDR_BUS and BUS_RW_n equal the CPU values each cycle
  - BUS_DATA_OUT = 5A on the write
  - CPU_ENABLE stays 1.
- Even-aligned DMA: preload $0300–$03FF with i^8'hA5, then write $4014 = 8'h03 with PARITY = 0 at HALT. Required:
  - CPU_ENABLE low for exactly 513 cycles
  - 256 writes to $2004 carrying data 8'hA5, 8'hA4, … in order
  - the last write is 8'h5A.
- Odd-aligned DMA (macro defined): same trigger with PARITY = 1 at HALT. Required:
  - one ALIGN cycle
  - halt = 514 cycles
  - identical data sequence.
- Macro undefined: the odd-parity trigger gives halt = 513 cycles.
- Reset mid-transfer: assert RESET_n low at IDX = 8'h40 during WRITE. Required, at the next edge:
  - STATE = IDLE
  - CPU_ENABLE = 1
  - DMA_ACTIVE = 0
  - no further $2004 writes.
- Non-triggers: a CPU read of $4014, and a write to $4015. Required: DMA_ACTIVE stays 0 and CPU_ENABLE stays 1.
